// File: rtl/test_add4.sv
// test_add4: registered 4-bit carry-lookahead adder; {C1,S} = A+B+C0 one cycle after in_valid.
// Defining TEST_OVF_EN adds the registered two's-complement overflow output V.
module test_add4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       C0,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       out_valid,
  output logic [3:0] S,
  output logic       C1
`ifdef TEST_OVF_EN
  ,
  output logic       V
`endif
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;
  logic       pg_s;
  logic       gg_s;
  logic [3:0] sum_s;

  logic [3:0] s_q;
  logic [3:0] s_d;
  logic       c1_q;
  logic       c1_d;
  logic       out_valid_q;
  logic       out_valid_d;
`ifdef TEST_OVF_EN
  logic       v_q;
  logic       v_d;
`endif

  // Generate/propagate terms and flattened two-level lookahead carries
  always_comb begin
    g_s    = A & B;
    p_s    = A ^ B;
    c_s[0] = C0;
    c_s[1] = g_s[0] | (p_s[0] & C0);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & C0);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & C0);
    pg_s   = &p_s;
    gg_s   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    c_s[4] = gg_s | (pg_s & C0);
    sum_s  = p_s ^ c_s[3:0];
  end

  // Next state: load a fresh result on in_valid, otherwise hold so idle-cycle X never reaches outputs
  always_comb begin
    s_d         = s_q;
    c1_d        = c1_q;
    out_valid_d = 1'b0;
`ifdef TEST_OVF_EN
    v_d         = v_q;
`endif
    if (in_valid) begin
      s_d         = sum_s;
      c1_d        = c_s[4];
      out_valid_d = 1'b1;
`ifdef TEST_OVF_EN
      v_d         = c_s[3] ^ c_s[4];
`endif
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers; reset wins over in_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= 4'b0000;
      c1_q        <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef TEST_OVF_EN
      v_q         <= 1'b0;
`endif
    end else begin
      s_q         <= s_d;
      c1_q        <= c1_d;
      out_valid_q <= out_valid_d;
`ifdef TEST_OVF_EN
      v_q         <= v_d;
`endif
    end
  end

  assign S         = s_q;
  assign C1        = c1_q;
  assign out_valid = out_valid_q;
`ifdef TEST_OVF_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_test_add4.sv
// Scoreboard bench for test_add4: the driver pushes the expected per-cycle output, a monitor pops and compares.
// Define TEST_OVF_EN to also check V.
module tb_test_add4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       C0;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic [3:0] S;
  logic       C1;
`ifdef TEST_OVF_EN
  logic       V;
`endif

  typedef struct {
    logic       ov;
    logic [3:0] s;
    logic       c1;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: the last accepted result
  logic [3:0] m_s  = 4'd0;
  logic       m_c1 = 1'b0;
  logic       m_v  = 1'b0;

  test_add4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .C0       (C0),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .S        (S),
    .C1       (C1)
`ifdef TEST_OVF_EN
    ,
    .V        (V)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic vld, input logic c,
                       input logic [3:0] a, input logic [3:0] b);
    int   sum;
    int   ssum;
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    in_valid = vld;
    C0       = c;
    A        = a;
    B        = b;
    if (!r) begin
      m_s  = 4'd0;
      m_c1 = 1'b0;
      m_v  = 1'b0;
      e.ov = 1'b0;
    end else if (vld) begin
      sum  = int'(a) + int'(b) + int'(c);
      ssum = int'($signed(a)) + int'($signed(b)) + int'(c);
      m_s  = sum[3:0];
      m_c1 = (sum > 15);
      m_v  = (ssum > 7) || (ssum < -8);
      e.ov = 1'b1;
    end else begin
      e.ov = 1'b0;
    end
    e.s  = m_s;
    e.c1 = m_c1;
    e.v  = m_v;
    q.push_back(e);
  endtask

  // Monitor: one expected record per clock edge once stimulus has started
  initial begin
    exp_t e;
    logic v_ok;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        v_ok = 1'b1;
`ifdef TEST_OVF_EN
        v_ok = (V === e.v);
`endif
        if (out_valid !== e.ov || S !== e.s || C1 !== e.c1 || !v_ok) begin
          bad++;
          $display("FAIL result @%0t: got ov=%b S=%b C1=%b, want ov=%b S=%b C1=%b V=%b",
                   $time, out_valid, S, C1, e.ov, e.s, e.c1, e.v);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    C0       = 1'b0;
    A        = 4'b1111;
    B        = 4'b1111;
    // Reset held with valid inputs present
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111);
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111);
    // Directed sums
    drive(1'b1, 1'b1, 1'b0, 4'b0001, 4'b0100);
    drive(1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 4'b0101, 4'b1010);
    drive(1'b1, 1'b1, 1'b0, 4'b0001, 4'b1111);
    // Hold, with unknown inputs while idle
    drive(1'b1, 1'b1, 1'b0, 4'b0011, 4'b0010);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000);
    drive(1'b1, 1'b0, 1'bx, 4'bxxxx, 4'bxxxx);
    // Signed-overflow corners
    drive(1'b1, 1'b1, 1'b0, 4'b0111, 4'b0001);
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 4'b1000);
    drive(1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010);
    // Exhaustive back-to-back
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b1, i[8], i[7:4], i[3:0]);
    end
    // Mid-stream reset discards the sampled op; next valid accepted
    drive(1'b1, 1'b1, 1'b0, 4'b1001, 4'b0100);
    drive(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0011);
    drive(1'b1, 1'b1, 1'b0, 4'b0110, 4'b0011);
    // Random traffic with idle cycles and occasional reset
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 4'($urandom), 4'($urandom));
    end
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected results never checked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
